// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl_if
//  Purpose  : Bundles the request, ALU and response channels of the shared
//             ALU issue controller. slave = controller side, master = the
//             requesters/ALU/consumer side.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if;
    // Request channel, two requesters packed {req1, req0}
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [11:0] req_instr;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [31:0] req_value;
    logic [1:0]  req_highlow;
    // ALU drive
    logic [5:0]  alu_instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [15:0] alu_value;
    logic        alu_highlow;
    // ALU results
    logic [31:0] alu_c;
    logic        alu_f3;
    logic        alu_addrch;
    logic [31:0] alu_naddr;
    // Response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_c;
    logic        rsp_f3;
    logic        rsp_addrch;
    logic [31:0] rsp_naddr;
    logic        busy;

    modport slave (
        input  req_valid, req_instr, req_a, req_b, req_value, req_highlow,
        input  alu_c, alu_f3, alu_addrch, alu_naddr,
        input  rsp_ready,
        output req_ready,
        output alu_instr, alu_a, alu_b, alu_value, alu_highlow,
        output rsp_valid, rsp_id, rsp_c, rsp_f3, rsp_addrch, rsp_naddr, busy
    );

    modport master (
        output req_valid, req_instr, req_a, req_b, req_value, req_highlow,
        output alu_c, alu_f3, alu_addrch, alu_naddr,
        output rsp_ready,
        input  req_ready,
        input  alu_instr, alu_a, alu_b, alu_value, alu_highlow,
        input  rsp_valid, rsp_id, rsp_c, rsp_f3, rsp_addrch, rsp_naddr, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Shares one 32-bit ALU between two requesters. Round-robin grant,
//             operands held on the ALU for ALU_LAT cycles, result returned
//             over a valid/ready response channel.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int         ALU_LAT    = 1,
    parameter logic [5:0] IDLE_INSTR = 6'd63
) (
    input  wire logic       clock,
    input  wire logic       reset,
    alu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int                 c_CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(ALU_LAT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ptr;      // requester favoured when both are valid
    logic               r_id;
    logic [5:0]         r_alu_instr;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [15:0]        r_alu_value;
    logic               r_alu_highlow;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_c;
    logic               r_rsp_f3;
    logic               r_rsp_addrch;
    logic [31:0]        r_rsp_naddr;
    logic               r_busy;

    logic               w_grant;
    logic               w_xfer;

    // Round-robin pick: lone requester wins, ties go to the pointer
    always_comb begin
        w_grant = 1'b0;
        case (bus.req_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = r_ptr;
            default: w_grant = 1'b0;
        endcase
    end

    // Transfers only happen in IDLE with at least one valid requester
    assign w_xfer        = (r_state == S_IDLE) && (|bus.req_valid) && !reset;
    assign bus.req_ready = w_xfer ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

    assign bus.alu_instr   = r_alu_instr;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_value   = r_alu_value;
    assign bus.alu_highlow = r_alu_highlow;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_id      = r_id;
    assign bus.rsp_c       = r_rsp_c;
    assign bus.rsp_f3      = r_rsp_f3;
    assign bus.rsp_addrch  = r_rsp_addrch;
    assign bus.rsp_naddr   = r_rsp_naddr;
    assign bus.busy        = r_busy;

    // Issue FSM: latch winner onto the ALU, hold for ALU_LAT cycles, capture, respond
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_ptr         <= 1'b0;
            r_id          <= 1'b0;
            r_alu_instr   <= IDLE_INSTR;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_value   <= '0;
            r_alu_highlow <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_c       <= '0;
            r_rsp_f3      <= 1'b0;
            r_rsp_addrch  <= 1'b0;
            r_rsp_naddr   <= '0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_alu_instr   <= w_grant ? bus.req_instr[11:6]  : bus.req_instr[5:0];
                        r_alu_a       <= w_grant ? bus.req_a[63:32]     : bus.req_a[31:0];
                        r_alu_b       <= w_grant ? bus.req_b[63:32]     : bus.req_b[31:0];
                        r_alu_value   <= w_grant ? bus.req_value[31:16] : bus.req_value[15:0];
                        r_alu_highlow <= bus.req_highlow[w_grant];
                        r_id          <= w_grant;
                        r_ptr         <= ~w_grant;
                        r_cnt         <= c_LAT;
                        r_busy        <= 1'b1;
                        r_state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == c_ONE) begin
                        // F3 is only meaningful as sampled on this rising edge
                        r_rsp_c       <= bus.alu_c;
                        r_rsp_f3      <= bus.alu_f3;
                        r_rsp_addrch  <= bus.alu_addrch;
                        r_rsp_naddr   <= bus.alu_naddr;
                        r_rsp_valid   <= 1'b1;
                        r_alu_instr   <= IDLE_INSTR;
                        r_alu_a       <= '0;
                        r_alu_b       <= '0;
                        r_alu_value   <= '0;
                        r_alu_highlow <= 1'b0;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Purpose  : Self-checking bench for alu_issue_ctrl. Two instances (ALU_LAT=1
//             and ALU_LAT=3) share one stimulus source; sel picks the active
//             one. A mock ALU returns garbage until its inputs have been
//             stable for ALU_LAT cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [31:0] c;
        logic        f3;
        logic        ach;
        logic [31:0] naddr;
    } res_t;

    typedef struct packed {
        logic        id;
        logic [5:0]  instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] value;
        logic        hl;
        res_t        res;
    } exp_t;

    typedef struct {
        int          who;
        logic [5:0]  instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] value;
        logic        hl;
        logic [31:0] exp_c;
        logic        exp_f3;
        logic        exp_ach;
        logic [31:0] exp_naddr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic [1:0]  d_valid;
    logic [11:0] d_instr;
    logic [63:0] d_a;
    logic [63:0] d_b;
    logic [31:0] d_value;
    logic [1:0]  d_hl;
    logic        d_rsp_ready;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl_if if1 ();
    alu_issue_ctrl_if if3 ();

    alu_issue_ctrl #(.ALU_LAT(1), .IDLE_INSTR(6'd63)) u_dut1 (.clock(clk), .reset(rst), .bus(if1));
    alu_issue_ctrl #(.ALU_LAT(3), .IDLE_INSTR(6'd63)) u_dut3 (.clock(clk), .reset(rst), .bus(if3));

    assign if1.req_valid   = sel ? 2'b00 : d_valid;
    assign if3.req_valid   = sel ? d_valid : 2'b00;
    assign if1.rsp_ready   = sel ? 1'b1 : d_rsp_ready;
    assign if3.rsp_ready   = sel ? d_rsp_ready : 1'b1;
    assign if1.req_instr   = d_instr;
    assign if3.req_instr   = d_instr;
    assign if1.req_a       = d_a;
    assign if3.req_a       = d_a;
    assign if1.req_b       = d_b;
    assign if3.req_b       = d_b;
    assign if1.req_value   = d_value;
    assign if3.req_value   = d_value;
    assign if1.req_highlow = d_hl;
    assign if3.req_highlow = d_hl;

    // Reference ALU behaviour used by the mock and the scoreboard
    function automatic res_t alu_fn(input logic [5:0] ins, input logic [31:0] a, input logic [31:0] b,
                                    input logic [15:0] v, input logic hl);
        res_t r;
        r = '0;
        case (ins)
            6'd0:    r.c = a + b;
            6'd1:    r.c = a - b;
            6'd2:    r.c = a & b;
            6'd5:    r.c = hl ? {v, a[15:0]} : {a[31:16], v};
            6'd8:    begin r.c = a - b; r.f3 = (a == b); end
            6'd14:   begin r.c = a; r.ach = 1'b1; r.naddr = 32'h100; end
            6'd63:   r = '0;
            default: r.c = a ^ b ^ {26'd0, ins};
        endcase
        return r;
    endfunction

    function automatic res_t mock(input logic [5:0] ins, input logic [31:0] a, input logic [31:0] b,
                                  input logic [15:0] v, input logic hl, input int age, input int lat);
        if (age < lat - 1) return {32'hDEAD_BEEF, 1'b1, 1'b1, 32'hBAD0_BAD0};
        return alu_fn(ins, a, b, v, hl);
    endfunction

    // Mock ALU: age counts cycles the ALU inputs have been unchanged
    int          age1 = 0;
    int          age3 = 0;
    logic [86:0] prev1 = '0;
    logic [86:0] prev3 = '0;
    res_t        res1;
    res_t        res3;

    always @(negedge clk) begin
        age1  <= ({if1.alu_instr, if1.alu_a, if1.alu_b, if1.alu_value, if1.alu_highlow} == prev1) ? age1 + 1 : 0;
        prev1 <= {if1.alu_instr, if1.alu_a, if1.alu_b, if1.alu_value, if1.alu_highlow};
        age3  <= ({if3.alu_instr, if3.alu_a, if3.alu_b, if3.alu_value, if3.alu_highlow} == prev3) ? age3 + 1 : 0;
        prev3 <= {if3.alu_instr, if3.alu_a, if3.alu_b, if3.alu_value, if3.alu_highlow};
    end

    always_comb res1 = mock(if1.alu_instr, if1.alu_a, if1.alu_b, if1.alu_value, if1.alu_highlow, age1, 1);
    always_comb res3 = mock(if3.alu_instr, if3.alu_a, if3.alu_b, if3.alu_value, if3.alu_highlow, age3, 3);

    assign if1.alu_c      = res1.c;
    assign if1.alu_f3     = res1.f3;
    assign if1.alu_addrch = res1.ach;
    assign if1.alu_naddr  = res1.naddr;
    assign if3.alu_c      = res3.c;
    assign if3.alu_f3     = res3.f3;
    assign if3.alu_addrch = res3.ach;
    assign if3.alu_naddr  = res3.naddr;

    // Observed outputs of the active instance
    logic [1:0]  w_ready;
    logic        w_busy, w_rsp_valid, w_rsp_id, w_rsp_f3, w_rsp_ach, w_alu_hl;
    logic [31:0] w_rsp_c, w_rsp_naddr, w_alu_a, w_alu_b;
    logic [5:0]  w_alu_instr;
    logic [15:0] w_alu_value;
    assign w_ready     = sel ? if3.req_ready   : if1.req_ready;
    assign w_busy      = sel ? if3.busy        : if1.busy;
    assign w_rsp_valid = sel ? if3.rsp_valid   : if1.rsp_valid;
    assign w_rsp_id    = sel ? if3.rsp_id      : if1.rsp_id;
    assign w_rsp_c     = sel ? if3.rsp_c       : if1.rsp_c;
    assign w_rsp_f3    = sel ? if3.rsp_f3      : if1.rsp_f3;
    assign w_rsp_ach   = sel ? if3.rsp_addrch  : if1.rsp_addrch;
    assign w_rsp_naddr = sel ? if3.rsp_naddr   : if1.rsp_naddr;
    assign w_alu_instr = sel ? if3.alu_instr   : if1.alu_instr;
    assign w_alu_a     = sel ? if3.alu_a       : if1.alu_a;
    assign w_alu_b     = sel ? if3.alu_b       : if1.alu_b;
    assign w_alu_value = sel ? if3.alu_value   : if1.alu_value;
    assign w_alu_hl    = sel ? if3.alu_highlow : if1.alu_highlow;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard model of the controller, evaluated once per cycle at negedge
    exp_t        q[$];
    logic        id_log[$];
    int          m_st  = 0;    // 0 idle, 1 exec, 2 resp
    int          m_cnt = 0;
    logic        m_ptr = 1'b0;
    logic        m_g;
    logic [1:0]  m_rdy;
    exp_t        m_e;
    int          n_rsp = 0;
    logic [31:0] rec_c, rec_naddr;
    logic        rec_f3, rec_ach, rec_id;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("ready_in_reset", w_ready, 0);
                m_st = 0;
                m_ptr = 1'b0;
                q.delete();
            end else begin
                m_g   = (d_valid == 2'b11) ? m_ptr : d_valid[1];
                m_rdy = (m_st == 0 && d_valid != 2'b00) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
                chk("req_ready", w_ready, m_rdy);
                chk("busy", w_busy, m_st != 0);
                chk("rsp_valid", w_rsp_valid, m_st == 2);
                if (m_st == 1 && q.size() > 0)
                    chk("alu_drive", {w_alu_instr, w_alu_a, w_alu_b, w_alu_value, w_alu_hl},
                        {q[0].instr, q[0].a, q[0].b, q[0].value, q[0].hl});
                else if (m_st != 1)
                    chk("alu_idle", {w_alu_instr, w_alu_a, w_alu_b, w_alu_value, w_alu_hl},
                        {6'd63, 32'd0, 32'd0, 16'd0, 1'b0});
                if (m_st == 2 && q.size() > 0)
                    chk("rsp_fields", {w_rsp_id, w_rsp_c, w_rsp_f3, w_rsp_ach, w_rsp_naddr},
                        {q[0].id, q[0].res});
                case (m_st)
                    0: if (d_valid != 2'b00) begin
                        m_e.id    = m_g;
                        m_e.instr = m_g ? d_instr[11:6] : d_instr[5:0];
                        m_e.a     = m_g ? d_a[63:32] : d_a[31:0];
                        m_e.b     = m_g ? d_b[63:32] : d_b[31:0];
                        m_e.value = m_g ? d_value[31:16] : d_value[15:0];
                        m_e.hl    = d_hl[m_g];
                        m_e.res   = alu_fn(m_e.instr, m_e.a, m_e.b, m_e.value, m_e.hl);
                        q.push_back(m_e);
                        m_ptr = ~m_g;
                        m_cnt = sel ? 3 : 1;
                        m_st  = 1;
                    end
                    1: if (m_cnt == 1) m_st = 2; else m_cnt--;
                    default: if (d_rsp_ready) begin
                        rec_c = w_rsp_c; rec_f3 = w_rsp_f3; rec_ach = w_rsp_ach;
                        rec_naddr = w_rsp_naddr; rec_id = w_rsp_id;
                        id_log.push_back(w_rsp_id);
                        n_rsp++;
                        if (q.size() > 0) void'(q.pop_front());
                        m_st = 0;
                    end
                endcase
            end
        end
    end

    task automatic set_op(input int n, input logic [5:0] ins, input logic [31:0] a, input logic [31:0] b,
                          input logic [15:0] v, input logic hl);
        if (n == 0) begin
            d_instr[5:0] = ins; d_a[31:0] = a; d_b[31:0] = b; d_value[15:0] = v; d_hl[0] = hl;
        end else begin
            d_instr[11:6] = ins; d_a[63:32] = a; d_b[63:32] = b; d_value[31:16] = v; d_hl[1] = hl;
        end
    endtask

    task automatic wait_ready(output logic [1:0] r);
        r = 2'b00;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (w_ready != 2'b00) begin
                r = w_ready;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL wait_ready: got no grant expected a grant within 50 cycles");
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (n_rsp >= target) return;
        end
        checks++; errors++;
        $display("FAIL wait_rsp: got %0d responses expected %0d", n_rsp, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    vec_t       vt[7];
    logic [1:0] r;
    int         base;
    int         idb;
    logic       found;

    initial begin
        vt[0] = '{0, 6'd0,  32'd5,          32'd7,          16'd0,      1'b0, 32'd12,         1'b0, 1'b0, 32'd0};
        vt[1] = '{1, 6'd1,  32'd100,        32'd1,          16'd0,      1'b0, 32'd99,         1'b0, 1'b0, 32'd0};
        vt[2] = '{0, 6'd8,  32'd9,          32'd9,          16'd0,      1'b0, 32'd0,          1'b1, 1'b0, 32'd0};
        vt[3] = '{1, 6'd14, 32'h55,         32'd0,          16'd0,      1'b0, 32'h55,         1'b0, 1'b1, 32'h100};
        vt[4] = '{0, 6'd40, 32'hF0F0_0000,  32'h0000_0F0F,  16'd0,      1'b0, 32'hF0F0_0F27,  1'b0, 1'b0, 32'd0};
        vt[5] = '{1, 6'd5,  32'h1234_5678,  32'd0,          16'hBEEF,   1'b0, 32'h1234_BEEF,  1'b0, 1'b0, 32'd0};
        vt[6] = '{0, 6'd2,  32'hFF00_FF00,  32'h0FF0_0FF0,  16'd0,      1'b0, 32'h0F00_0F00,  1'b0, 1'b0, 32'd0};

        rst = 1'b1; sel = 1'b0; d_valid = 2'b00; d_rsp_ready = 1'b1;
        d_instr = '0; d_a = '0; d_b = '0; d_value = '0; d_hl = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp", {w_rsp_c, w_rsp_f3, w_rsp_ach, w_rsp_naddr, w_rsp_id}, 0);
        chk("reset_alu_instr", w_alu_instr, 6'd63);

        // Table vectors on the ALU_LAT=1 instance
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            base = n_rsp;
            set_op(vt[i].who, vt[i].instr, vt[i].a, vt[i].b, vt[i].value, vt[i].hl);
            d_valid = (vt[i].who == 1) ? 2'b10 : 2'b01;
            wait_ready(r);
            chk("tv_grant", r, (vt[i].who == 1) ? 2'b10 : 2'b01);
            @(posedge clk); #1 d_valid = 2'b00;
            wait_rsp(base + 1);
            chk("tv_c", rec_c, vt[i].exp_c);
            chk("tv_flags", {rec_f3, rec_ach}, {vt[i].exp_f3, vt[i].exp_ach});
            chk("tv_naddr", rec_naddr, vt[i].exp_naddr);
            chk("tv_id", rec_id, vt[i].who == 1);
        end

        // Single op cycle timing with ALU_LAT=1
        @(posedge clk); #1;
        set_op(0, 6'd0, 32'd5, 32'd7, 16'd0, 1'b0);
        d_valid = 2'b01;
        wait_ready(r);
        chk("t1_grant", r, 2'b01);
        @(posedge clk); #1 d_valid = 2'b00;
        @(negedge clk);
        chk("t1_exec", {w_busy, w_rsp_valid, w_alu_a}, {1'b1, 1'b0, 32'd5});
        @(negedge clk);
        chk("t1_rsp", {w_rsp_valid, w_rsp_c, w_rsp_id}, {1'b1, 32'd12, 1'b0});
        @(negedge clk);
        chk("t1_busy_low", w_busy, 1'b0);

        // Backpressure: response held, other requester waits
        @(posedge clk); #1;
        base = n_rsp;
        d_rsp_ready = 1'b0;
        set_op(1, 6'd0, 32'h1000, 32'h0234, 16'd0, 1'b0);
        set_op(0, 6'd1, 32'd50, 32'd8, 16'd0, 1'b0);
        d_valid = 2'b10;
        wait_ready(r);
        chk("t3_grant", r, 2'b10);
        @(posedge clk); #1 d_valid = 2'b01;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = w_rsp_valid;
        end
        chk("t3_rsp_seen", found, 1'b1);
        chk("t3_first_c", w_rsp_c, 32'h1234);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_hold", {w_rsp_valid, w_rsp_c, w_rsp_id, w_ready}, {1'b1, 32'h1234, 1'b1, 2'b00});
        end
        @(posedge clk); #1 d_rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_handshake", {w_rsp_valid, w_ready}, {1'b1, 2'b00});
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_resume", w_ready, 2'b01);
        @(posedge clk); #1 d_valid = 2'b00;
        wait_rsp(base + 2);
        chk("t3_second", {rec_id, rec_c}, {1'b0, 32'd42});

        // ALU_LAT=3 hold and latency
        @(posedge clk); #1;
        sel = 1'b1;
        base = n_rsp;
        set_op(0, 6'd5, 32'h1234_5678, 32'd0, 16'hBEEF, 1'b1);
        d_valid = 2'b01;
        wait_ready(r);
        chk("t5_grant", r, 2'b01);
        @(posedge clk); #1 d_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_alu_hold", {w_alu_instr, w_alu_a, w_alu_value, w_alu_hl, w_rsp_valid},
                {6'd5, 32'h1234_5678, 16'hBEEF, 1'b1, 1'b0});
        end
        @(negedge clk);
        chk("t5_rsp", {w_rsp_valid, w_rsp_c}, {1'b1, 32'hBEEF_5678});
        wait_rsp(base + 1);

        // Reset in the middle of EXEC
        @(posedge clk); #1;
        base = n_rsp;
        set_op(1, 6'd0, 32'd1, 32'd2, 16'd0, 1'b0);
        d_valid = 2'b10;
        wait_ready(r);
        @(posedge clk); #1 d_valid = 2'b00; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_after_reset", {w_busy, w_rsp_valid, w_alu_instr, w_alu_a, w_ready},
            {1'b0, 1'b0, 6'd63, 32'd0, 2'b00});
        chk("t6_rsp_cleared", {w_rsp_c, w_rsp_f3, w_rsp_ach, w_rsp_naddr, w_rsp_id}, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6_no_rsp", w_rsp_valid, 1'b0);
        end
        chk("t6_dropped", n_rsp, base);

        // Contention: both valid, four ops, first grant after reset goes to req0
        @(posedge clk); #1;
        base = n_rsp;
        idb  = id_log.size();
        set_op(0, 6'd0, 32'd10, 32'd1, 16'd0, 1'b0);
        set_op(1, 6'd1, 32'd20, 32'd1, 16'd0, 1'b0);
        d_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ready(r);
            chk("t2_grant", r, (k % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            if (k == 3) d_valid = 2'b00;
            else set_op(r[1] ? 1 : 0, 6'd0, 32'd100 + k, 32'd3, 16'd0, 1'b0);
        end
        wait_rsp(base + 4);
        chk("t2_count", id_log.size(), idb + 4);
        if (id_log.size() >= idb + 4)
            for (int k = 0; k < 4; k++) chk("t2_id", id_log[idb + k], k % 2);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
